// File: rtl/mpc_mul_share_arb.sv
// Round-robin arbiter sharing one MUL_LAT-stage signed x unsigned multiplier between NUM_REQ requesters.
// Optional build macro MPC_MUL_ARB_SAT_EN: signed-saturate the product to RSP_W bits instead of truncating.
module mpc_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 21,
  parameter int B_W     = 12,
  parameter int P_W     = 34,
  parameter int RSP_W   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*A_W-1:0]   a_in,
  input  logic [NUM_REQ*B_W-1:0]   b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     mul_ce,
  output logic [A_W-1:0]           mul_a,
  output logic [B_W-1:0]           mul_b,
  input  logic [P_W-1:0]           mul_p,
  output logic [NUM_REQ-1:0]       rsp_vld,
  output logic [RSP_W-1:0]         rsp_p,
  output logic                     busy
);

  localparam int TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] winner;
  logic             found;
  logic             accept;

  logic             issue_vld;
  logic [TAG_W-1:0] issue_tag;
  logic [MUL_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]   pipe_tag [MUL_LAT];

  // Scan starting at ptr; the first requester found in wrap order wins.
  always_comb begin
    int idx;
    logic [TAG_W-1:0] idx_t;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_t  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_t = TAG_W'(idx);
      if (!found && req[idx_t]) begin
        found  = 1'b1;
        winner = idx_t;
      end
    end
  end

  // Reset gating keeps gnt low for the whole time reset is asserted.
  assign accept = found & ce & reset;
  assign gnt    = accept ? (NUM_REQ'(1) << winner) : '0;
  assign mul_ce = ce;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      issue_vld <= 1'b0;
      issue_tag <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      pipe_vld  <= '0;
      for (int k = 0; k < MUL_LAT; k++) pipe_tag[k] <= '0;
    end else if (ce) begin
      issue_vld <= accept;
      if (accept) begin
        ptr       <= (winner == TAG_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        issue_tag <= winner;
        mul_a     <= a_in[winner*A_W +: A_W];
        mul_b     <= b_in[winner*B_W +: B_W];
      end
      // Tag/valid shadow of the multiplier; last stage lines up with mul_p.
      pipe_vld[0] <= issue_vld;
      pipe_tag[0] <= issue_tag;
      for (int k = 1; k < MUL_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

  assign rsp_vld = (pipe_vld[MUL_LAT-1] & ce) ? (NUM_REQ'(1) << pipe_tag[MUL_LAT-1]) : '0;
  assign busy    = issue_vld | (|pipe_vld);

`ifdef MPC_MUL_ARB_SAT_EN
  logic in_range;
  // In range when every bit above the result sign bit matches the product sign.
  assign in_range = (mul_p[P_W-1:RSP_W-1] == {(P_W-RSP_W+1){mul_p[P_W-1]}});
  assign rsp_p    = in_range      ? mul_p[RSP_W-1:0] :
                    mul_p[P_W-1]  ? {1'b1, {(RSP_W-1){1'b0}}} :
                                    {1'b0, {(RSP_W-1){1'b1}}};
`else
  logic unused_p_hi;
  assign unused_p_hi = ^mul_p[P_W-1:RSP_W];
  assign rsp_p       = mul_p[RSP_W-1:0];
`endif

endmodule

// File: tb/tb_mpc_mul_share_arb.sv
// Bench for mpc_mul_share_arb: random traffic scored against a queue-based arbitration/latency model.
module tb_mpc_mul_share_arb;
  localparam int NUM_REQ = 4;
  localparam int A_W     = 21;
  localparam int B_W     = 12;
  localparam int P_W     = 34;
  localparam int RSP_W   = 32;
  localparam int MUL_LAT = 4;
  localparam int RSP_DLY = MUL_LAT + 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   ce;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*A_W-1:0] a_in;
  logic [NUM_REQ*B_W-1:0] b_in;
  logic [NUM_REQ-1:0]     gnt;
  logic                   mul_ce;
  logic [A_W-1:0]         mul_a;
  logic [B_W-1:0]         mul_b;
  logic [P_W-1:0]         mul_p;
  logic [NUM_REQ-1:0]     rsp_vld;
  logic [RSP_W-1:0]       rsp_p;
  logic                   busy;

  int n_checks = 0;
  int n_errors = 0;

  mpc_mul_share_arb #(
    .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .RSP_W(RSP_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_vld(rsp_vld), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the DSP multiplier: MUL_LAT register stages, frozen when mul_ce is low.
  logic signed [P_W-1:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= $signed(mul_a) * $signed({1'b0, mul_b});
      for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign mul_p = mpipe[MUL_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pointer, enabled-cycle counter and a queue of scheduled responses.
  typedef struct {
    int             id;
    longint         due;
    logic [RSP_W-1:0] p;
  } exp_t;
  exp_t   q[$];
  int     mptr = 0;
  longint ecnt = 0;

  function automatic logic [RSP_W-1:0] ref_rsp(input longint prod);
    logic [63:0] pv;
    longint pmax;
    longint pmin;
    pmax = (longint'(1) << (RSP_W - 1)) - 1;
    pmin = -(longint'(1) << (RSP_W - 1));
`ifdef MPC_MUL_ARB_SAT_EN
    if (prod > pmax) return {1'b0, {(RSP_W-1){1'b1}}};
    if (prod < pmin) return {1'b1, {(RSP_W-1){1'b0}}};
`else
    if (pmax < pmin) return '0;
`endif
    pv = prod;
    return pv[RSP_W-1:0];
  endfunction

  // Check outputs mid-cycle, then apply the effect of the coming edge to the model.
  task automatic step();
    int w;
    int idx;
    logic [NUM_REQ-1:0] eg;
    logic [NUM_REQ-1:0] ev;
    logic signed [A_W-1:0] av;
    logic [B_W-1:0] bv;
    exp_t e;
    @(negedge clk);
    w = -1;
    if (reset && ce) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (mptr + k) % NUM_REQ;
        if (w < 0 && req[idx]) w = idx;
      end
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    ev = '0;
    if (reset && ce && q.size() != 0 && q[0].due == ecnt) ev[q[0].id] = 1'b1;
    check("gnt", 64'(gnt), 64'(eg));
    check("mul_ce", 64'(mul_ce), 64'(ce));
    check("rsp_vld", 64'(rsp_vld), 64'(ev));
    if (ev != 0) check("rsp_p", 64'(rsp_p), 64'(q[0].p));
    check("busy", 64'(busy), 64'(reset && q.size() != 0));
    if (!reset) begin
      q.delete();
      mptr = 0;
    end else if (ce) begin
      if (ev != 0) void'(q.pop_front());
      if (w >= 0) begin
        av = a_in[w*A_W +: A_W];
        bv = b_in[w*B_W +: B_W];
        e.id  = w;
        e.due = ecnt + RSP_DLY;
        e.p   = ref_rsp(longint'(av) * longint'(bv));
        q.push_back(e);
        mptr = (w + 1) % NUM_REQ;
      end
      ecnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_ops();
    logic [A_W-1:0] amin;
    logic [A_W-1:0] amax;
    amin = {1'b1, {(A_W-1){1'b0}}};
    amax = {1'b0, {(A_W-1){1'b1}}};
    for (int i = 0; i < NUM_REQ; i++) begin
      case ($urandom_range(0, 7))
        0:       a_in[i*A_W +: A_W] = amin;
        1:       a_in[i*A_W +: A_W] = amax;
        2:       a_in[i*A_W +: A_W] = '0;
        default: a_in[i*A_W +: A_W] = A_W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b_in[i*B_W +: B_W] = '1;
        1:       b_in[i*B_W +: B_W] = '0;
        default: b_in[i*B_W +: B_W] = B_W'($urandom);
      endcase
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*A_W +: A_W] = A_W'(a);
    b_in[i*B_W +: B_W] = B_W'(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'(0));
    check({tag, "_rsp_vld"}, 64'(rsp_vld), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_mul_a"}, 64'(mul_a), 64'(0));
    check({tag, "_mul_b"}, 64'(mul_b), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    req   = '1;
    a_in  = '0;
    b_in  = '0;
    #1 reset = 1'b0;
    #2 check_reset_outputs("reset");
    step();
    reset = 1'b1;
    req   = '0;

    // Single request: -3 * 5
    set_op(0, -3, 5);
    req = 4'b0001;
    step();
    idle(7);

    // All requesters held: rotating grants, one response per cycle
    rand_ops();
    req = '1;
    for (int i = 0; i < 8; i++) step();
    idle(7);

    // Pointer skip and wrap: grant 2 leaves ptr=3, then 0101 -> 0 then 2
    rand_ops();
    req = 4'b0100;
    step();
    req = 4'b0101;
    step();
    step();
    idle(7);

    // Clock-enable stall in the middle of a flight
    rand_ops();
    req = 4'b0001;
    step();
    req = '0;
    step();
    ce  = 1'b0;
    req = '1;
    for (int i = 0; i < 3; i++) step();
    ce = 1'b1;
    idle(7);

    // Reset while three operations are in flight
    rand_ops();
    req = '1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    #1 check_reset_outputs("midrst");
    step();
    reset = 1'b1;
    idle(7);

    // Product range extremes (truncation or saturation depending on build)
    set_op(0, -1048576, 4095);
    req = 4'b0001;
    step();
    set_op(1, 1048575, 4095);
    req = 4'b0010;
    step();
    set_op(2, -1, 4095);
    req = 4'b0100;
    step();
    idle(7);

    // Random traffic with occasional stalls
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      req = NUM_REQ'($urandom);
      ce  = ($urandom_range(0, 4) != 0);
      step();
    end
    ce = 1'b1;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
